fp_add_arbiter: RTL

//  Shares one combinational fp_adder (1b sign, 4b exp, 8b frac) between two requesters.

---
 rtl/fp_add_arbiter_if.sv | 42 ++++
 rtl/fp_add_arbiter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/fp_add_arbiter_if.sv
// ----------------------------------------------------------------------------
// fp_add_arbiter_if
// Purpose : Bundles the two requester channels and the result channel of the
//           shared floating-point adder arbiter.
// Signals : req0_valid/req0_ready/req0_a/req0_b  requester 0 operand channel
//           req1_valid/req1_ready/req1_a/req1_b  requester 1 operand channel
//           res_valid/res_ready                   result handshake
//           res_data/res_id/res_ovf               sum, owner ID, overflow flag
//           Operands and sum are packed {sign[12], exp[11:8], frac[7:0]}.
// Modports: master = producers/consumer side, slave = arbiter side.
// ----------------------------------------------------------------------------
interface fp_add_arbiter_if;
   logic        req0_valid;
   logic        req0_ready;
   logic [12:0] req0_a;
   logic [12:0] req0_b;
   logic        req1_valid;
   logic        req1_ready;
   logic [12:0] req1_a;
   logic [12:0] req1_b;
   logic        res_valid;
   logic        res_ready;
   logic [12:0] res_data;
   logic        res_id;
   logic        res_ovf;

   modport master (
      output req0_valid, req0_a, req0_b,
      output req1_valid, req1_a, req1_b,
      output res_ready,
      input  req0_ready, req1_ready,
      input  res_valid, res_data, res_id, res_ovf
   );

   modport slave (
      input  req0_valid, req0_a, req0_b,
      input  req1_valid, req1_a, req1_b,
      input  res_ready,
      output req0_ready, req1_ready,
      output res_valid, res_data, res_id, res_ovf
   );
endinterface

// File: rtl/fp_add_arbiter.sv
// ----------------------------------------------------------------------------
// fp_add_arbiter
// Purpose : Shares one combinational floating-point adder between two
//           requesters. A winner's operand pair is latched in IDLE, the sum is
//           registered in CALC and presented in OUT until the consumer takes it.
//           Exponent wrap on a same-sign add saturates the result and raises
//           res_ovf.
// Format  : {sign[12], exp[11:8], frac[7:0]}, frac carries an explicit leading
//           one in bit 7; no rounding (bits shifted out are dropped).
// Ports   : clk    clock, rising edge
//           reset  synchronous active-high reset
//           bus    fp_add_arbiter_if.slave (requester and result channels)
// Params  : ARB_MODE     0 = round-robin, 1 = fixed priority to req0 with a
//                        starvation guard for req1
//           STARVE_LIMIT consecutive req0 grants while req1 waits before req1
//                        is forced (ARB_MODE=1), 1..15
// ----------------------------------------------------------------------------
module fp_add_arbiter #(
   parameter int unsigned ARB_MODE     = 0,
   parameter int unsigned STARVE_LIMIT = 3
) (
   input  logic              clk,
   input  logic              reset,
   fp_add_arbiter_if.slave   bus
);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_OUT} state_t;

   state_t      state_q, state_d;
   logic [12:0] a_q, a_d;
   logic [12:0] b_q, b_d;
   logic        id_q, id_d;
   logic        last_id_q, last_id_d;
   logic [3:0]  wait_cnt_q, wait_cnt_d;
   logic [12:0] res_data_q, res_data_d;
   logic        res_id_q, res_id_d;
   logic        res_ovf_q, res_ovf_d;

   logic        win;
   logic [12:0] sum;
   logic [3:0]  exp_max;
   logic        ovf;

   // Shared adder: align the smaller magnitude, add/subtract, renormalise.
   function automatic logic [12:0] fp_add(input logic [12:0] a, input logic [12:0] b);
      logic       a_big;
      logic       s_big, s_sml;
      logic [3:0] e_big, e_sml, e_res;
      logic [7:0] f_big, f_sml, f_shf, f_res;
      logic [8:0] mag;
      a_big = (a[11:8] > b[11:8]) || ((a[11:8] == b[11:8]) && (a[7:0] >= b[7:0]));
      s_big = a_big ? a[12]   : b[12];
      s_sml = a_big ? b[12]   : a[12];
      e_big = a_big ? a[11:8] : b[11:8];
      e_sml = a_big ? b[11:8] : a[11:8];
      f_big = a_big ? a[7:0]  : b[7:0];
      f_sml = a_big ? b[7:0]  : a[7:0];
      f_shf = f_sml >> (e_big - e_sml);
      if (s_big == s_sml) mag = {1'b0, f_big} + {1'b0, f_shf};
      else                mag = {1'b0, f_big} - {1'b0, f_shf};
      // Carry out: shift right and bump the exponent (wraps 15 -> 0).
      if (mag[8]) begin
         f_res = mag[8:1];
         e_res = e_big + 4'd1;
      end else begin
         f_res = mag[7:0];
         e_res = e_big;
      end
      // Cancellation: restore the leading one while the exponent allows it.
      for (int i = 0; i < 8; i++) begin
         if (!f_res[7] && (f_res != 8'h00) && (e_res != 4'h0)) begin
            f_res = f_res << 1;
            e_res = e_res - 4'd1;
         end
      end
      if (f_res == 8'h00) e_res = 4'h0;
      return {s_big, e_res, f_res};
   endfunction

   // Largest representable magnitude with the operands' sign.
   function automatic logic [12:0] sat_max(input logic sign);
      return {sign, 4'hF, 8'hFF};
   endfunction

   assign sum     = fp_add(a_q, b_q);
   assign exp_max = (a_q[11:8] > b_q[11:8]) ? a_q[11:8] : b_q[11:8];
   // Exponent wrap can only come from a same-sign add at the top exponent.
   assign ovf     = (a_q[12] == b_q[12]) && (exp_max == 4'hF) && (sum[11:8] == 4'h0);

   // Winner selection; only meaningful when at least one requester is valid.
   always_comb begin
      win = bus.req1_valid;
      if (bus.req0_valid && bus.req1_valid) begin
         if (ARB_MODE == 0) win = ~last_id_q;
         else               win = (wait_cnt_q == 4'(STARVE_LIMIT));
      end
   end

   assign bus.req0_ready = (state_q == S_IDLE) && bus.req0_valid && !win;
   assign bus.req1_ready = (state_q == S_IDLE) && bus.req1_valid &&  win;
   assign bus.res_valid  = (state_q == S_OUT);
   assign bus.res_data   = res_data_q;
   assign bus.res_id     = res_id_q;
   assign bus.res_ovf    = res_ovf_q;

   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      id_d       = id_q;
      last_id_d  = last_id_q;
      wait_cnt_d = wait_cnt_q;
      res_data_d = res_data_q;
      res_id_d   = res_id_q;
      res_ovf_d  = res_ovf_q;
      case (state_q)
         S_IDLE: begin
            if (bus.req0_valid || bus.req1_valid) begin
               a_d       = win ? bus.req1_a : bus.req0_a;
               b_d       = win ? bus.req1_b : bus.req0_b;
               id_d      = win;
               last_id_d = win;
               // Count req0 grants taken while req1 was waiting.
               if (!win && bus.req1_valid)
                  wait_cnt_d = (wait_cnt_q == 4'hF) ? 4'hF : wait_cnt_q + 4'd1;
               else
                  wait_cnt_d = 4'h0;
               state_d = S_CALC;
            end
         end
         S_CALC: begin
            res_id_d  = id_q;
            res_ovf_d = ovf;
            if (ovf)                       res_data_d = sat_max(a_q[12]);
            else if (sum[11:0] == 12'h000) res_data_d = 13'h0000;
            else                           res_data_d = sum;
            state_d = S_OUT;
         end
         S_OUT: begin
            if (bus.res_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         a_q        <= 13'h0000;
         b_q        <= 13'h0000;
         id_q       <= 1'b0;
         last_id_q  <= 1'b1;
         wait_cnt_q <= 4'h0;
         res_data_q <= 13'h0000;
         res_id_q   <= 1'b0;
         res_ovf_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         b_q        <= b_d;
         id_q       <= id_d;
         last_id_q  <= last_id_d;
         wait_cnt_q <= wait_cnt_d;
         res_data_q <= res_data_d;
         res_id_q   <= res_id_d;
         res_ovf_q  <= res_ovf_d;
      end
   end

endmodule
